fetch_unit: RTL and testbench

Instruction fetch sequencer for the 8-bit CPU: keeps the fetch program counter, reads 16-bit instruction words from a synchronous-read instruction memory, and presents each instruction with its 4-bit opcode to the decode/control stage over a valid/ready handshake. It consumes the decode stage's `jump` result to redirect the PC, and it stops on the HALT opcode.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives a synchronous-read instruction memory from the
// fetch PC and hands each word to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter logic [3:0]           HALT_OP  = 4'b1111
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               imem_re,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               halted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        VALID  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    fpc_q;
    logic [ADDR_W-1:0]    fpc_d;
    logic [INSTR_W-1:0]   instr_q;
    logic [ADDR_W-1:0]    pc_q;
    logic                 imem_re_q;
    logic                 valid_q;
    logic                 halted_q;
    logic                 accept;

    assign accept = valid_q & instr_ready;

    // Next fetch address after a non-HALT accept; the increment wraps silently.
    always_comb begin
        fpc_d = fpc_q + ADDR_W'(1);
        if (jump) begin
            fpc_d = jump_addr;
        end
    end

    // NOTE: every register here uses non-blocking assignments so all state updates
    // see the pre-edge values; the async reset clears them without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fpc_q     <= RESET_PC;
            instr_q   <= '0;
            pc_q      <= RESET_PC;
            imem_re_q <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q   <= REQ;
                        imem_re_q <= 1'b1;
                    end
                end
                REQ: begin
                    state_q   <= WAIT;
                    imem_re_q <= 1'b0;
                end
                WAIT: begin
                    instr_q <= imem_rdata;
                    pc_q    <= fpc_q;
                    valid_q <= 1'b1;
                    state_q <= VALID;
                end
                VALID: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (instr_q[INSTR_W-1 -: 4] == HALT_OP) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            fpc_q <= fpc_d;
                            if (en) begin
                                state_q   <= REQ;
                                imem_re_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q   <= IDLE;
                    imem_re_q <= 1'b0;
                    valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_re     = imem_re_q;
    assign imem_addr   = fpc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[INSTR_W-1 -: 4];
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses and
// accepted instructions; negedge monitors pop and compare.
module tb_fetch_unit;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        en, en2;
    logic        instr_ready, ready2;
    logic        jump;
    logic [7:0]  jump_addr;

    logic        imem_re, imem_re2;
    logic [7:0]  imem_addr, imem_addr2;
    logic [15:0] imem_rdata, imem_rdata2;
    logic [15:0] instr, instr2;
    logic [3:0]  opcode, opcode2;
    logic [7:0]  pc, pc2;
    logic        instr_valid, valid2;
    logic        halted, halted2;

    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];

    logic [7:0]  addr_q [$];
    exp_t        exp_q  [$];
    logic [7:0]  addr2_q [$];
    exp_t        exp2_q  [$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .imem_re(imem_re), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .pc(pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump(jump), .jump_addr(jump_addr), .halted(halted)
    );

    fetch_unit #(.RESET_PC(8'hFE)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en2),
        .imem_re(imem_re2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .instr(instr2), .opcode(opcode2), .pc(pc2),
        .instr_valid(valid2), .instr_ready(ready2),
        .jump(1'b0), .jump_addr(8'h00), .halted(halted2)
    );

    // Synchronous-read instruction memories.
    always @(posedge clk) begin
        if (imem_re)  imem_rdata  <= mem1[imem_addr];
        if (imem_re2) imem_rdata2 <= mem2[imem_addr2];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max);
        int n = 0;
        while (!instr_valid && n < max) begin
            step();
            n++;
        end
        check(name, {31'd0, instr_valid}, 32'd1);
    endtask

    // Monitor for the main instance.
    always @(negedge clk) begin
        logic [7:0] ea;
        exp_t       ei;
        if (rst_n === 1'b1) begin
            if (imem_re) begin
                tests++;
                if (addr_q.size() == 0) begin
                    fails++;
                    $display("FAIL fetch_addr: unexpected read at %h", imem_addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (imem_addr !== ea) begin
                        fails++;
                        $display("FAIL fetch_addr: got %h, expected %h", imem_addr, ea);
                    end
                end
            end
            if (instr_valid && instr_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL accept: unexpected accept pc=%h instr=%h", pc, instr);
                end else begin
                    ei = exp_q.pop_front();
                    if (pc !== ei.pc || instr !== ei.instr || opcode !== ei.instr[15:12]) begin
                        fails++;
                        $display("FAIL accept: got pc=%h instr=%h op=%h, expected pc=%h instr=%h op=%h",
                                 pc, instr, opcode, ei.pc, ei.instr, ei.instr[15:12]);
                    end
                end
            end
        end
    end

    // Monitor for the RESET_PC=0xFE instance.
    always @(negedge clk) begin
        logic [7:0] ea;
        exp_t       ei;
        if (rst2_n === 1'b1) begin
            if (imem_re2) begin
                tests++;
                if (addr2_q.size() == 0) begin
                    fails++;
                    $display("FAIL fetch_addr2: unexpected read at %h", imem_addr2);
                end else begin
                    ea = addr2_q.pop_front();
                    if (imem_addr2 !== ea) begin
                        fails++;
                        $display("FAIL fetch_addr2: got %h, expected %h", imem_addr2, ea);
                    end
                end
            end
            if (valid2 && ready2) begin
                tests++;
                if (exp2_q.size() == 0) begin
                    fails++;
                    $display("FAIL accept2: unexpected accept pc=%h", pc2);
                end else begin
                    ei = exp2_q.pop_front();
                    if (pc2 !== ei.pc || instr2 !== ei.instr) begin
                        fails++;
                        $display("FAIL accept2: got pc=%h instr=%h, expected pc=%h instr=%h",
                                 pc2, instr2, ei.pc, ei.instr);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_re"},     {31'd0, imem_re}, 32'd0);
        check({tag, "_addr"},   {24'd0, imem_addr}, 32'h00);
        check({tag, "_instr"},  {16'd0, instr}, 32'h0000);
        check({tag, "_opcode"}, {28'd0, opcode}, 32'h0);
        check({tag, "_pc"},     {24'd0, pc}, 32'h00);
        check({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        int re_count;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0000;
            mem2[i] = {8'h10, i[7:0]};
        end
        mem1[0]     = 16'h1123;
        mem1[1]     = 16'h2456;
        mem1[2]     = 16'h3000;
        mem1[3]     = 16'h4000;
        mem1[4]     = 16'h7777;
        mem1[5]     = 16'hF000;
        mem1[8'h40] = 16'h6ABC;
        mem1[8'h80] = 16'h9999;

        rst_n = 1'b0; rst2_n = 1'b0;
        en = 1'b0; en2 = 1'b0;
        instr_ready = 1'b0; ready2 = 1'b1;
        jump = 1'b0; jump_addr = 8'h00;
        #22;
        check_reset_outputs("reset");

        // Sequential fetch with a backpressured word, a jump, then HALT.
        addr_q = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h04, 8'h05};
        exp_q  = '{'{8'h00, 16'h1123}, '{8'h01, 16'h2456}, '{8'h02, 16'h3000},
                   '{8'h40, 16'h6ABC}, '{8'h04, 16'h7777}, '{8'h05, 16'hF000}};
        @(posedge clk); #1;
        en = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
        step();
        check("req_cycle1", {31'd0, imem_re}, 32'd1);
        step();
        check("wait_re_low", {31'd0, imem_re}, 32'd0);
        step();
        check("valid_cycle3", {31'd0, instr_valid}, 32'd1);
        step();
        check("req_after_accept", {23'd0, imem_re, imem_addr}, {23'd0, 1'b1, 8'h01});
        instr_ready = 1'b0;

        wait_valid("valid_pc1", 10);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {7'd0, instr_valid, imem_re, instr}, {7'd0, 1'b1, 1'b0, 16'h2456});
            if (i == 2) begin
                jump = 1'b1; jump_addr = 8'h80;
            end else begin
                jump = 1'b0;
            end
            step();
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("req_after_bp", {23'd0, imem_re, imem_addr}, {23'd0, 1'b1, 8'h02});

        wait_valid("valid_pc2", 10);
        jump = 1'b1; jump_addr = 8'h40; instr_ready = 1'b1;
        step();
        jump = 1'b0; instr_ready = 1'b0;
        check("jump_req", {23'd0, imem_re, imem_addr}, {23'd0, 1'b1, 8'h40});

        wait_valid("valid_pc40", 10);
        jump = 1'b1; jump_addr = 8'h04; instr_ready = 1'b1;
        step();
        jump = 1'b0;
        check("jump_req2", {23'd0, imem_re, imem_addr}, {23'd0, 1'b1, 8'h04});

        for (int i = 0; i < 20 && !halted; i++) step();
        check("halted_set", {30'd0, halted, instr_valid}, {30'd0, 1'b1, 1'b0});
        re_count = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_re || instr_valid) re_count++;
        end
        check("halted_quiet", re_count, 0);
        check("halted_stays", {31'd0, halted}, 32'd1);

        // Reset out of HALTED, then drop en during WAIT.
        rst_n = 1'b0;
        #2;
        check("halt_reset_halted", {31'd0, halted}, 32'd0);
        check("halt_reset_addr", {24'd0, imem_addr}, 32'h00);
        instr_ready = 1'b0;
        addr_q.push_back(8'h00);
        exp_q.push_back('{8'h00, 16'h1123});
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        check("restart_req", {23'd0, imem_re, imem_addr}, {23'd0, 1'b1, 8'h00});
        step();
        en = 1'b0;
        step();
        check("en_drop_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        re_count = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_re || instr_valid) re_count++;
            step();
        end
        check("idle_after_drop", re_count, 0);
        check("idle_fpc_advanced", {24'd0, imem_addr}, 32'h01);

        addr_q.push_back(8'h01);
        exp_q.push_back('{8'h01, 16'h2456});
        en = 1'b1;
        step();
        check("reen_req", {23'd0, imem_re, imem_addr}, {23'd0, 1'b1, 8'h01});
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_wait_reset");
        void'(exp_q.pop_back());
        check("queue_addr_empty", addr_q.size(), 0);
        check("queue_exp_empty", exp_q.size(), 0);

        // RESET_PC=0xFE instance: sequential fetch across the wrap.
        addr2_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp2_q  = '{'{8'hFE, 16'h10FE}, '{8'hFF, 16'h10FF},
                    '{8'h00, 16'h1000}, '{8'h01, 16'h1001}};
        @(posedge clk); #1;
        check("wrap_reset_addr", {24'd0, imem_addr2}, 32'hFE);
        en2 = 1'b1; rst2_n = 1'b1;
        for (int i = 0; i < 11; i++) step();
        en2 = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("wrap_idle_addr", {24'd0, imem_addr2}, 32'h02);
        check("queue_addr2_empty", addr2_q.size(), 0);
        check("queue_exp2_empty", exp2_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
